// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM condition-code and flag definitions
package arm_pkg;

  // Flag vector is {N,Z,C,V}
  localparam int FLAGS_W = 4;
  localparam int FLAG_N  = 3;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_C  = 1;
  localparam int FLAG_V  = 0;

  typedef logic [FLAGS_W-1:0] flags_t;

  // Instruction Cond field encodings, bits [31:28]
  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - evaluates an ARM condition code against stored flags
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // One arm per condition code; NV is executed unconditionally like AL
  always_comb begin
    cond_ex = 1'b1;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = !z;
      CS: cond_ex = c;
      CC: cond_ex = !c;
      MI: cond_ex = n;
      PL: cond_ex = !n;
      VS: cond_ex = v;
      VC: cond_ex = !v;
      HI: cond_ex = c & !z;
      LS: cond_ex = !c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = !z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - NZCV flag register and conditional write-strobe gating
module cond_logic #(
  parameter int FLAGS_W = arm_pkg::FLAGS_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         Cond,
  input  logic [FLAGS_W-1:0] ALUFlags,
  input  logic [1:0]         FlagW,
  input  logic               PCS,
  input  logic               RegW,
  input  logic               MemW,
  input  logic               NoWrite,
  input  logic               Stall,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               CondEx,
  output logic [FLAGS_W-1:0] Flags
);

  import arm_pkg::*;

  flags_t flags_q;
  logic   ok;

  // Condition is judged only on registered flags, so flags written by one
  // instruction affect the next one, never the one producing them.
  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (CondEx)
  );

  // NZ and CV halves update independently; a failed or stalled instruction
  // leaves both untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (!Stall && CondEx) begin
      if (FlagW[1]) flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[0]) flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Write strobes are squashed in reset, on stall and on a failed condition
  always_comb begin
    ok       = reset_n & !Stall & CondEx;
    PCSrc    = PCS & ok;
    RegWrite = RegW & !NoWrite & ok;
    MemWrite = MemW & ok;
  end

  assign Flags = flags_q;

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the ARM instruction decoder.
- Consumes the decoder's PCS/RegW/MemW/NoWrite/FlagW, the instruction Cond field and the ALU's NZCV result.
- Holds the architectural NZCV flag register and evaluates all 16 ARM condition codes against the stored flags.
- Gates the final PCSrc/RegWrite/MemWrite strobes into the datapath.

Parameters:
- FLAGS_W, 4, width of the flag vector, ordered {N,Z,C,V}; fixed at 4, exposed only for package consistency.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- Cond  input  4  instruction bits [31:28]
- ALUFlags  input  4  ALU result flags {N,Z,C,V} of the current instruction
- FlagW  input  2  from decoder: [1] = update N,Z; [0] = update C,V
- PCS  input  1  from decoder: instruction writes PC
- RegW  input  1  from decoder: instruction writes register file
- MemW  input  1  from decoder: instruction writes data memory
- NoWrite  input  1  from decoder: compare-class op, suppress register write
- Stall  input  1  hold state and squash all write strobes this cycle
- PCSrc  output  1  gated PC-write select
- RegWrite  output  1  gated register-file write enable
- MemWrite  output  1  gated data-memory write enable
- CondEx  output  1  condition passed for current instruction
- Flags  output  4  current registered {N,Z,C,V}, for debug/observation

Behaviour:
- Flags register: 4 flops, synchronous reset to 4'b0000 when reset_n=0 at a rising clk.
- CondEx: combinational from Cond and registered Flags only, never from same-cycle ALUFlags.
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as AL, CondEx=1
- Flag update at rising clk when reset_n=1 and Stall=0:
  - Flags[3:2] <= ALUFlags[3:2] iff FlagW[1]&CondEx.
  - Flags[1:0] <= ALUFlags[1:0] iff FlagW[0]&CondEx.
  - Otherwise each half holds.
- Output gating, combinational, with ok = reset_n & !Stall & CondEx:
  - PCSrc = PCS & ok
  - RegWrite = RegW & !NoWrite & ok
  - MemWrite = MemW & ok
- Latency: flags written by instruction i are visible to CondEx of instruction i+1 (one cycle later). Write strobes have zero latency.
- Reset mid-operation: while reset_n=0, all three strobes are forced 0 regardless of inputs. Flags clear on the next edge.
- Stall=1: flags hold, strobes 0, CondEx still reports the evaluated condition.
- Simultaneous failing condition and FlagW≠0: flags unchanged. A failed conditional CMP must not alter flags.
- No X propagation: all outputs are defined for every input combination once reset has been applied.

Decomposition:
- Shared package arm_pkg:
  - cond_e enum (EQ..AL, NV=4'hF)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - flags_t typedef (logic [3:0])
- Sub-module cond_check: purely combinational, Cond + Flags -> CondEx, one case over cond_e.
- Top level holds only the flag flops and gating.

Test Plan:
- Reset: reset_n=0 for 2 cycles with PCS=RegW=MemW=1, Cond=AL -> PCSrc=RegWrite=MemWrite=0, then Flags=0000.
- CMP then BEQ: Cond=AL, FlagW=11, NoWrite=1, RegW=1, ALUFlags=0100 -> RegWrite=0 that cycle, Flags=0100 next cycle. Then Cond=EQ, PCS=1 -> CondEx=1, PCSrc=1. Then Cond=NE -> PCSrc=0.
- Partial write: Flags=1111, FlagW=10, ALUFlags=0000 -> Flags=0011 (C,V preserved).
- Failed conditional CMP: Flags=0000, Cond=EQ, FlagW=11, ALUFlags=1111 -> CondEx=0, Flags stay 0000, all strobes 0.
- Signed conditions: Flags=1001 (N=1,V=1) -> GE=1, LT=0, GT=1, LE=0. Flags=1000 -> GE=0, LT=1, GT=0, LE=1.
- Stall: Stall=1, Cond=AL, FlagW=11, MemW=1, ALUFlags=1010 -> MemWrite=0, Flags unchanged. Deassert Stall -> MemWrite=1, Flags=1010 next edge.
